memory_responder: RTL and testbench
===================================

// Module: memory_responder
// PURPOSE
//  Responder (slave) end of the core's load/store memory channel: accepts one request from an initiator
//  (instruction fetch or data port), performs it on an internal word-addressed RAM and returns one response.
//  Sits between a core bus port and on-chip storage; one instance per port in simulation/FPGA builds.
//  Single outstanding transaction, fixed programmable latency, full valid/ready backpressure on both channels.
// PARAMETERS
//  DEPTH_WORDS  1024   RAM size in 32-bit words; power of two, >= 2
//  BASE_ADDR    32'h0  byte address of word 0; aligned to DEPTH_WORDS*4
//  LATENCY      1      cycles from request accept to rsp_valid; 1..15
// PORTS
//  clock      in   1   single clock; all state updates on posedge
//  reset      in   1   synchronous, active-high
//  req_valid  in   1   initiator presents a request
//  req_ready  out  1   responder can accept a request this cycle
//  req_write  in   1   1 = store, 0 = load
//  req_addr   in   32  byte address
//  req_data   in   32  store data
//  req_strb   in   4   store byte enables; bit i -> req_data[8i+7:8i]
//  rsp_valid  out  1   response held until accepted
//  rsp_ready  in   1   initiator accepts response
//  rsp_data   out  32  load data; 32'h0 for stores and errors
//  rsp_error  out  1   request was out of range or misaligned
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0 during reset then 1 the cycle after reset deasserts, rsp_valid=0,
//   rsp_data=0, rsp_error=0, latency counter=0. RAM contents are not reset.
//  States: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1. On req_valid&&req_ready (accept edge): latch write/addr/strb, go WAIT, count=LATENCY-1.
//   WAIT: req_ready=0. count decrements each cycle; at count==0 go RESP.
//   RESP: rsp_valid=1, rsp_data/rsp_error stable. On rsp_valid&&rsp_ready go IDLE.
//   With LATENCY=1, WAIT lasts zero cycles: request accepted at edge N, rsp_valid=1 in cycle N+1.
//   General: accept at edge N -> rsp_valid first high in cycle N+LATENCY.
//  Throughput: one transaction per LATENCY+1 cycles when rsp_ready is held high.
//  Address: index = (req_addr - BASE_ADDR) >> 2, width $clog2(DEPTH_WORDS).
//  Store: RAM written on the accept edge under req_strb; strb=0 writes nothing but still returns a response.
//  Load: RAM read on the accept edge into the response register; a later store does not alter it.
//  Read-after-write: a load accepted after a store's response sees the stored data.
//  req_* ignored when req_ready=0; a request must stay valid until accepted (checked by assertion).
//  Reset mid-transaction: pending response discarded, no rsp_valid; a store already accepted stays written.
// CONFIGURATION
//  MEMORY_RESPONDER_ERR_EN defined: req_addr[1:0]!=0 or address outside
//   [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) -> no RAM access, rsp_error=1, rsp_data=0, same latency.
//  Not defined: rsp_error tied 0; req_addr[1:0] ignored; index taken modulo DEPTH_WORDS (aliases wrap).
// TESTING
//  1. Reset, store addr 0x10 data 0xAAAAAAAA strb 4'hF, then load 0x10 -> rsp_data=0xAAAAAAAA, rsp_error=0.
//  2. LATENCY=3: accept at edge N -> rsp_valid low in N+1 and N+2, high in N+3; req_ready low until handshake.
//  3. Word 0x20 = 0x11223344, store 0xFFFFFFFF strb 4'b0101, load -> 0x11FF33FF.
//  4. Hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data stable, req_ready=0; release -> IDLE next cycle.
//  5. ERR_EN: load 0x3 -> rsp_error=1, data 0; load BASE_ADDR+4*DEPTH_WORDS -> error. Without ERR_EN:
//     that load returns word 0.
//  6. Assert reset in WAIT -> no rsp_valid afterwards; req_ready=1 the cycle after reset drops.

Source files
------------

// File: rtl/memory_responder_if.sv
// Request/response channel between a core bus port (master) and memory_responder (slave).
interface memory_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [3:0]  req_strb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_error;

   modport master (
      output req_valid, req_write, req_addr, req_data, req_strb, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_data, req_strb, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_error
   );
endinterface

// File: rtl/memory_responder.sv
// Single-outstanding load/store responder on a word-addressed RAM with fixed response latency.
// Define MEMORY_RESPONDER_ERR_EN to flag misaligned/out-of-range requests instead of aliasing.
module memory_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int unsigned LATENCY     = 1
) (
   input  logic               i_clock,
   input  logic               i_reset,
   memory_responder_if.slave  io_bus
);
   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      r_state;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic        r_rsp_error;
   logic [31:0] r_rsp_data;
   logic [3:0]  r_count;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic [31:0]      w_offset;
   logic [IDX_W-1:0] w_index;
   logic             w_err;
   logic             w_accept;
   logic             w_wr_en;
   logic             w_rsp_done;
   logic             w_unused;

   assign w_offset = io_bus.req_addr - BASE_ADDR;
   assign w_index  = w_offset[IDX_W+1:2];
   assign w_unused = &{1'b0, w_offset};

`ifdef MEMORY_RESPONDER_ERR_EN
   assign w_err = (io_bus.req_addr[1:0] != 2'b00) || ((w_offset >> 2) >= 32'(DEPTH_WORDS));
`else
   assign w_err = 1'b0;
`endif

   // Nothing is accepted while reset is asserted, so a reset cannot launch a store.
   assign w_accept   = io_bus.req_valid && r_req_ready && !i_reset;
   assign w_wr_en    = w_accept && io_bus.req_write && !w_err;
   assign w_rsp_done = r_rsp_valid && io_bus.rsp_ready;

   // NOTE: the RAM array is deliberately left out of reset so it can map onto block RAM.
   always_ff @(posedge i_clock) begin
      if (w_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (io_bus.req_strb[b]) r_mem[w_index][8*b +: 8] <= io_bus.req_data[8*b +: 8];
         end
      end
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_error <= 1'b0;
         r_count     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  r_rsp_error <= w_err;
                  r_rsp_data  <= (io_bus.req_write || w_err) ? '0 : r_mem[w_index];
                  if (LATENCY <= 1) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                  end else begin
                     r_state <= S_WAIT;
                     r_count <= 4'(LATENCY - 1);
                  end
               end else begin
                  r_req_ready <= 1'b1;
               end
            end
            S_WAIT: begin
               if (r_count <= 4'd1) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_count     <= '0;
               end else begin
                  r_count <= r_count - 4'd1;
               end
            end
            S_RESP: begin
               if (w_rsp_done) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_data  <= '0;
                  r_rsp_error <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.req_ready = r_req_ready && !i_reset;
   assign io_bus.rsp_valid = r_rsp_valid;
   assign io_bus.rsp_data  = r_rsp_data;
   assign io_bus.rsp_error = r_rsp_error;

   a_req_held: assert property (@(posedge i_clock) disable iff (i_reset)
      (io_bus.req_valid && !io_bus.req_ready) |=> io_bus.req_valid);
endmodule

// File: tb/tb_memory_responder.sv
// Randomized self-checking bench for memory_responder against an array-based reference model.
module tb_memory_responder;
   localparam int unsigned DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int unsigned LAT   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   longint cycle = 0;
   logic [31:0] model_mem [DEPTH];

   memory_responder_if bus ();

   memory_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .io_bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish, required completion before 200us");
      $fatal(1, "watchdog");
   end

   // Reference: word array, error rule and aliasing computed straight from the address map.
   task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [31:0] exp_data, output logic exp_err);
      logic [31:0] off;
      int idx;
      off = addr - BASE;
`ifdef MEMORY_RESPONDER_ERR_EN
      exp_err = (addr[1:0] != 2'b00) || (off >= 4 * DEPTH);
`else
      exp_err = 1'b0;
`endif
      idx = int'((off / 4) % DEPTH);
      exp_data = 32'h0;
      if (!exp_err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
         end else begin
            exp_data = model_mem[idx];
         end
      end
   endtask

   task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output longint acc_cycle);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_data  = data;
      bus.req_strb  = strb;
      while (bus.req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL req_ready_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, n);
      end
      @(posedge clk);
      @(negedge clk);
      acc_cycle = cycle;
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_data  = $urandom;
      bus.req_strb  = 4'($urandom);
   endtask

   // Called in the cycle after the accept edge; lat counts that cycle as 1.
   task automatic wait_rsp(output int lat, output logic ready_low);
      lat = 1;
      ready_low = 1'b1;
      while (bus.rsp_valid !== 1'b1 && lat < 50) begin
         if (bus.req_ready !== 1'b0) ready_low = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (bus.req_ready !== 1'b0) ready_low = 1'b0;
      if (lat >= 50) begin
         checks++;
         errors++;
         $display("FAIL rsp_valid_timeout: rsp_valid=%b after %0d cycles, required 1", bus.rsp_valid, lat);
      end
   endtask

   task automatic finish_rsp();
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         output logic [31:0] act_data, output logic act_err,
                         output logic [31:0] exp_data, output logic exp_err, output int lat);
      longint acc;
      logic rl;
      model_access(wr, addr, data, strb, exp_data, exp_err);
      start_req(wr, addr, data, strb, acc);
      wait_rsp(lat, rl);
      act_data = bus.rsp_data;
      act_err  = bus.rsp_error;
      finish_rsp();
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      bus.req_strb  = '0;
      bus.rsp_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b valid=%b data=%h err=%b, required 0 0 00000000 0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_error);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: req_ready=%b, required 1", bus.req_ready);
      end
   endtask

   task automatic prefill();
      logic [31:0] ad, ed;
      logic ae, ee;
      int lat;
      for (int i = 0; i < DEPTH; i++)
         do_txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, ad, ae, ed, ee, lat);
   endtask

   task automatic test_basic();
      logic [31:0] ad, ed;
      logic ae, ee;
      int lat;
      do_txn(1'b1, BASE + 32'h10, 32'hAAAA_AAAA, 4'hF, ad, ae, ed, ee, lat);
      checks++;
      if (ad !== 32'h0 || ae !== 1'b0) begin
         errors++;
         $display("FAIL store_response: data=%h err=%b, required 00000000 0", ad, ae);
      end
      do_txn(1'b0, BASE + 32'h10, 32'h0, 4'h0, ad, ae, ed, ee, lat);
      checks++;
      if (ad !== 32'hAAAA_AAAA || ae !== 1'b0) begin
         errors++;
         $display("FAIL load_after_store: data=%h err=%b, required aaaaaaaa 0", ad, ae);
      end
   endtask

   task automatic test_latency();
      longint acc;
      int lat;
      logic rl;
      logic [31:0] ed;
      logic ee;
      model_access(1'b0, BASE + 32'h10, 32'h0, 4'h0, ed, ee);
      start_req(1'b0, BASE + 32'h10, 32'h0, 4'h0, acc);
      wait_rsp(lat, rl);
      checks++;
      if (lat != LAT || rl !== 1'b1 || bus.rsp_data !== ed) begin
         errors++;
         $display("FAIL latency: lat=%0d ready_low=%b data=%h, required %0d 1 %h", lat, rl, bus.rsp_data, LAT, ed);
      end
      finish_rsp();
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_return_idle: ready=%b valid=%b, required 1 0", bus.req_ready, bus.rsp_valid);
      end
   endtask

   task automatic test_strobe();
      logic [31:0] ad, ed;
      logic ae, ee;
      int lat;
      do_txn(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF, ad, ae, ed, ee, lat);
      do_txn(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'b0101, ad, ae, ed, ee, lat);
      do_txn(1'b0, BASE + 32'h20, 32'h0, 4'h0, ad, ae, ed, ee, lat);
      checks++;
      if (ad !== 32'h11FF_33FF) begin
         errors++;
         $display("FAIL strobe_merge: data=%h, required 11ff33ff", ad);
      end
      do_txn(1'b1, BASE + 32'h20, 32'h0, 4'h0, ad, ae, ed, ee, lat);
      checks++;
      if (lat != LAT || ad !== 32'h0 || ae !== 1'b0) begin
         errors++;
         $display("FAIL strobe_zero_response: lat=%0d data=%h err=%b, required %0d 00000000 0", lat, ad, ae, LAT);
      end
      do_txn(1'b0, BASE + 32'h20, 32'h0, 4'h0, ad, ae, ed, ee, lat);
      checks++;
      if (ad !== 32'h11FF_33FF) begin
         errors++;
         $display("FAIL strobe_zero_nowrite: data=%h, required 11ff33ff", ad);
      end
   endtask

   task automatic test_backpressure();
      longint acc;
      int lat;
      logic rl, stable;
      logic [31:0] d0;
      bus.rsp_ready = 1'b0;
      start_req(1'b0, BASE + 32'h20, 32'h0, 4'h0, acc);
      wait_rsp(lat, rl);
      d0 = bus.rsp_data;
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 || bus.req_ready !== 1'b0) stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1 || d0 !== 32'h11FF_33FF) begin
         errors++;
         $display("FAIL backpressure_hold: stable=%b data=%h, required 1 11ff33ff", stable, d0);
      end
      finish_rsp();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release: valid=%b ready=%b, required 0 1", bus.rsp_valid, bus.req_ready);
      end
   endtask

   task automatic test_error();
      logic [31:0] ad, ed;
      logic ae, ee;
      int lat;
`ifdef MEMORY_RESPONDER_ERR_EN
      do_txn(1'b0, BASE + 32'h3, 32'h0, 4'h0, ad, ae, ed, ee, lat);
      checks++;
      if (ae !== 1'b1 || ad !== 32'h0 || lat != LAT) begin
         errors++;
         $display("FAIL err_misaligned: err=%b data=%h lat=%0d, required 1 00000000 %0d", ae, ad, lat, LAT);
      end
      do_txn(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, ad, ae, ed, ee, lat);
      checks++;
      if (ae !== 1'b1 || ad !== 32'h0) begin
         errors++;
         $display("FAIL err_range: err=%b data=%h, required 1 00000000", ae, ad);
      end
      do_txn(1'b1, BASE + 32'(4 * DEPTH), 32'hDEAD_BEEF, 4'hF, ad, ae, ed, ee, lat);
      do_txn(1'b0, BASE, 32'h0, 4'h0, ad, ae, ed, ee, lat);
      checks++;
      if (ad !== ed || ae !== 1'b0) begin
         errors++;
         $display("FAIL err_store_nowrite: data=%h err=%b, required %h 0", ad, ae, ed);
      end
`else
      do_txn(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, ad, ae, ed, ee, lat);
      checks++;
      if (ad !== ed || ae !== 1'b0) begin
         errors++;
         $display("FAIL alias_wrap: data=%h err=%b, required %h 0", ad, ae, ed);
      end
      do_txn(1'b0, BASE + 32'h13, 32'h0, 4'h0, ad, ae, ed, ee, lat);
      checks++;
      if (ad !== 32'hAAAA_AAAA || ae !== 1'b0) begin
         errors++;
         $display("FAIL alias_low_bits: data=%h err=%b, required aaaaaaaa 0", ad, ae);
      end
`endif
   endtask

   task automatic test_reset_mid();
      longint acc;
      logic [31:0] ad, ed;
      logic ae, ee, seen;
      int lat;
      model_access(1'b1, BASE + 32'h30, 32'hCAFE_F00D, 4'hF, ed, ee);
      start_req(1'b1, BASE + 32'h30, 32'hCAFE_F00D, 4'hF, acc);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_ready: ready=%b valid=%b, required 1 0", bus.req_ready, bus.rsp_valid);
      end
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_no_rsp: rsp_valid seen=%b, required 0", seen);
      end
      do_txn(1'b0, BASE + 32'h30, 32'h0, 4'h0, ad, ae, ed, ee, lat);
      checks++;
      if (ad !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL reset_mid_store_kept: data=%h, required cafef00d", ad);
      end
   endtask

   task automatic test_back_to_back();
      longint acc, prev;
      int lat;
      logic rl;
      logic [31:0] ed;
      logic ee;
      logic [31:0] addr;
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         addr = BASE + 32'(4 * $urandom_range(DEPTH - 1));
         model_access(1'b0, addr, 32'h0, 4'h0, ed, ee);
         start_req(1'b0, addr, 32'h0, 4'h0, acc);
         wait_rsp(lat, rl);
         checks++;
         if (bus.rsp_data !== ed || (i > 0 && acc - prev != longint'(LAT + 1))) begin
            errors++;
            $display("FAIL back_to_back[%0d]: data=%h spacing=%0d, required %h %0d", i, bus.rsp_data, acc - prev, ed, LAT + 1);
         end
         prev = acc;
         finish_rsp();
      end
   endtask

   task automatic test_random();
      longint acc;
      int lat, delay, kind;
      logic rl, wr;
      logic [31:0] addr, data, ed;
      logic [3:0] strb;
      logic ee;
      for (int i = 0; i < 300; i++) begin
         wr    = 1'($urandom);
         data  = $urandom;
         strb  = 4'($urandom);
         kind  = $urandom_range(7);
         delay = $urandom_range(2);
         if (kind == 0)      addr = BASE + 32'($urandom_range(4 * DEPTH - 1));
         else if (kind == 1) addr = (($urandom % 2) == 0) ? BASE - 32'h4 : BASE + 32'(4 * DEPTH + 4 * $urandom_range(15));
         else                addr = BASE + 32'(4 * $urandom_range(DEPTH - 1));
         model_access(wr, addr, data, strb, ed, ee);
         bus.rsp_ready = (delay == 0);
         start_req(wr, addr, data, strb, acc);
         wait_rsp(lat, rl);
         repeat (delay) @(negedge clk);
         checks++;
         if (lat != LAT || bus.rsp_data !== ed || bus.rsp_error !== ee || rl !== 1'b1) begin
            errors++;
            $display("FAIL random[%0d] wr=%b addr=%h: lat=%0d data=%h err=%b busy=%b, required %0d %h %b 1",
                     i, wr, addr, lat, bus.rsp_data, bus.rsp_error, rl, LAT, ed, ee);
         end
         finish_rsp();
      end
   endtask

   initial begin
      test_reset();
      prefill();
      test_basic();
      test_latency();
      test_strobe();
      test_backpressure();
      test_error();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
